// File: rtl/pkt_desc_fifo_ctrl.sv
// Packet-descriptor FIFO controller around an external 1R1W block RAM with
// a 1-cycle registered read. A 2-entry read-ahead stage hides the RAM read
// latency and presents first-word-fall-through valid/ready descriptors.

package pkt_desc_pkg;
  typedef struct packed {
    logic [7:0]  flags;
    logic [15:0] len;
    logic [23:0] addr;
  } pkt_desc_type;
endpackage

module pkt_desc_fifo_ctrl
  import pkt_desc_pkg::*;
#(
  parameter int DEPTH_NBITS  = 4,
  parameter int DEPTH        = 1 << DEPTH_NBITS,  // derived, keep consistent
  parameter int AFULL_THRESH = DEPTH - 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  pkt_desc_type           in_desc,
  output logic                   in_ready,
  output logic                   out_valid,
  output pkt_desc_type           out_desc,
  input  logic                   out_ready,
  output logic                   ram_wr,
  output logic [DEPTH_NBITS-1:0] ram_waddr,
  output pkt_desc_type           ram_din,
  output logic [DEPTH_NBITS-1:0] ram_raddr,
  input  pkt_desc_type           ram_dout,
  output logic [DEPTH_NBITS+1:0] desc_count,
  output logic                   desc_afull
);

  localparam int CW = DEPTH_NBITS + 2;
  localparam logic [DEPTH_NBITS:0] FULL = (DEPTH_NBITS+1)'(DEPTH);

  logic                   rst_q;
  logic [DEPTH_NBITS-1:0] wptr, rptr;
  logic [DEPTH_NBITS:0]   ram_used;
  logic                   rd_pend;
  logic [1:0]             ostage_occ;
  pkt_desc_type           ostage [2];

  logic                   accept, pop, issue;
  logic [2:0]             stage_load;
  logic [1:0]             occ_after_pop;
  logic [CW-1:0]          count_nxt;

  // Handshakes are decoded from registered state only, so in_ready has no
  // combinational path from in_valid or out_ready.
  assign in_ready  = !rst_q && (ram_used != FULL);
  assign accept    = in_valid && in_ready;
  assign out_valid = (ostage_occ != 2'd0);
  assign out_desc  = ostage[0];
  assign pop       = out_valid && out_ready;

  // Output-stage load after this cycle, counting a pending capture and a pop;
  // a new read may only be issued if its data will have a slot next cycle.
  assign stage_load    = 3'(ostage_occ) + 3'(rd_pend) - 3'(pop);
  assign issue         = (ram_used != '0) && (stage_load < 3'd2);
  assign occ_after_pop = ostage_occ - 2'(pop);

  assign ram_wr    = accept;
  assign ram_waddr = wptr;
  assign ram_din   = in_desc;
  assign ram_raddr = rptr;

  assign desc_count = CW'(ram_used) + CW'(rd_pend) + CW'(ostage_occ);
  assign count_nxt  = desc_count + CW'(accept) - CW'(pop);

  // Pointer, occupancy and almost-full bookkeeping.
  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      ram_used   <= '0;
      rd_pend    <= 1'b0;
      ostage_occ <= '0;
      desc_afull <= 1'b0;
    end else begin
      if (accept) wptr <= wptr + 1'b1;
      if (issue)  rptr <= rptr + 1'b1;
      case ({accept, issue})
        2'b10:   ram_used <= ram_used + 1'b1;
        2'b01:   ram_used <= ram_used - 1'b1;
        default: ;
      endcase
      rd_pend    <= issue;
      ostage_occ <= ostage_occ + 2'(rd_pend) - 2'(pop);
      desc_afull <= (count_nxt >= CW'(AFULL_THRESH));
    end
  end

  // Output-stage data: shift on pop, then land RAM data in the first free
  // slot; the later assignment wins when both target the head.
  always_ff @(posedge clk) begin
    if (pop) ostage[0] <= ostage[1];
    if (rd_pend) begin
      if (occ_after_pop == 2'd0) ostage[0] <= ram_dout;
      else                       ostage[1] <= ram_dout;
    end
  end

  a_no_accept_full: assert property (@(posedge clk) disable iff (rst)
    accept |-> (ram_used != FULL));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst)
    pop |-> (ostage_occ != 2'd0));
  a_pend_has_room: assert property (@(posedge clk) disable iff (rst)
    rd_pend |-> ((ostage_occ != 2'd2) || pop));

endmodule
